riscv_mem_stage: RTL and testbench
==================================

# riscv_mem_stage

MEM stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register and resolves branches (PC select and target). It performs loads and stores on the data memory over a req/gnt/rvalid handshake, stalling upstream stages while an access is outstanding. It registers results into the MEM/WB pipeline register.

## Interface
Parameters:
- XLEN, 32, data/address width; lane logic requires exactly 32.
- REGFILE_COUNT, 32, register count; `rd` width is $clog2(REGFILE_COUNT).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- alu_zero_i, alu_out_i, rs2_data_i, jp_addr_i  in  1/XLEN/XLEN/XLEN  EX results: zero flag, ALU result (also memory address), store data, branch target.
- rd_i  in  $clog2(REGFILE_COUNT)  destination register.
- funct3_i  in  3  access size/sign.
- mem_to_reg_i, reg_write_i, mem_read_i, mem_write_i, branch_i  in  1 each  control bits.
- dmem_req_o, dmem_we_o  out  1 each  memory request and write enable.
- dmem_addr_o  out  XLEN  word-aligned address, equal to {alu_out_i[XLEN-1:2], 2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  XLEN  store data.
- dmem_gnt_i, dmem_rvalid_i  in  1 each  grant and response valid.
- dmem_rdata_i  in  XLEN  read data.
- pc_src_o  out  1  branch taken, combinational: branch_i & alu_zero_i.
- branch_target_o  out  XLEN  combinational: jp_addr_i.
- stall_o  out  1  combinational; freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- mem_data_o, alu_out_o  out  XLEN each  registered to WB.
- rd_o  out  $clog2(REGFILE_COUNT)  registered to WB.
- mem_to_reg_o, reg_write_o  out  1 each  registered to WB.
- err_o  out  1  registered one-cycle pulse for an illegal access.

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- Access request: mem_read_i ^ mem_write_i, and the access is legal.
- Illegal access is any of the following:
  - mem_read_i & mem_write_i both set;
  - funct3_i is not LB/LH/LW/LBU/LHU (000/001/010/100/101) for a load, or not SB/SH/SW (000/001/010) for a store;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0.
- Illegal access handling: no request is issued, err_o=1 for one cycle, reg_write_o=0 and mem_to_reg_o=0 for that instruction, no stall.
- IDLE:
  - A legal access drives dmem_req_o=1 combinationally.
  - dmem_gnt_i=1 → WAIT; otherwise → REQ.
- REQ:
  - dmem_req_o=1 with addr, we, be and wdata stable.
  - dmem_gnt_i=1 → WAIT.
- WAIT:
  - dmem_req_o=0.
  - dmem_rvalid_i=1 → IDLE, and the WB register loads the result.
- dmem_rvalid_i is ignored in IDLE and REQ.
- stall_o=1 when either:
  - state is REQ or WAIT and dmem_rvalid_i is not completing a WAIT this cycle, or
  - state is IDLE and a legal access starts.
- stall_o is therefore 0 in the cycle rvalid arrives. EX/MEM inputs are held stable by the sender whenever stall_o=1.
- Stores:
  - dmem_we_o=1.
  - SB: be = 4'b0001 << addr[1:0], wdata = rs2[7:0] replicated ×4.
  - SH: be = 4'b0011 << addr[1:0], wdata = rs2[15:0] replicated ×2.
  - SW: be = 4'b1111, wdata = rs2.
- Loads:
  - dmem_we_o=0, be=4'b1111.
  - The byte/halfword is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata through.
- Stores also wait for dmem_rvalid_i before completing.
- WB register:
  - Loads when stall_o=0.
  - While stall_o=1 it loads a bubble: reg_write_o=0, mem_to_reg_o=0, err_o=0; data fields hold.
  - mem_data_o is updated only on load completion.
- Branch outputs are purely combinational and independent of the FSM.
- Reset: all registered outputs go to 0 and state goes to IDLE asynchronously; dmem_req_o drops immediately.

## Timing
- Non-memory instruction: results appear at the WB outputs one edge after the inputs are presented; no stall.
- Memory access with gnt in the request cycle and rvalid the next cycle: stall_o=1 for 1 cycle; the WB outputs update at the second edge.
- Each additional gnt or rvalid wait cycle adds one stall cycle.
- pc_src_o and branch_target_o have zero-cycle latency.
- err_o asserts at the edge following the illegal access.
- Reset asserted mid-access (REQ or WAIT): the outstanding transaction is abandoned. A late rvalid after reset release lands in IDLE and is ignored.

## Test plan
- ALU-only op: alu_out_i=0x1234, rd_i=5, reg_write_i=1 → next edge alu_out_o=0x1234, rd_o=5, reg_write_o=1; stall_o stays 0.
- LW at 0x100 with gnt immediate and rvalid next cycle with rdata=0xDEADBEEF → dmem_addr_o=0x100, stall_o high for 1 cycle, then mem_data_o=0xDEADBEEF, mem_to_reg_o=1, reg_write_o=1.
- LB at 0x103 with rdata=0x80000000 → mem_data_o=0xFFFFFF80. LBU at the same address → mem_data_o=0x00000080.
- SH at 0x102 with rs2=0x0000ABCD and gnt delayed 3 cycles:
  - req stays high for 4 cycles with stable addr=0x100, be=4'b1100, wdata=0xABCDABCD, we=1;
  - stall_o holds until rvalid;
  - reg_write_o=0 throughout.
- LW at 0x101, or mem_read_i=mem_write_i=1 → dmem_req_o never asserts, err_o=1 for one cycle, reg_write_o=0, no stall.
- Reset asserted in WAIT, then rvalid pulsed after release → all outputs 0, state IDLE, rvalid ignored. Separately, branch_i=1, alu_zero_i=1, jp_addr_i=0x400 → pc_src_o=1 and branch_target_o=0x400 in the same cycle.

Source files
------------

// File: rtl/riscv_mem_stage.sv
// MEM stage of the five-stage RISC-V pipeline.
// Resolves branches, runs data-memory loads/stores over req/gnt/rvalid,
// stalls upstream while an access is outstanding, and feeds the MEM/WB register.
module riscv_mem_stage #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned REGFILE_COUNT = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             alu_zero_i,
    input  logic [XLEN-1:0]                  alu_out_i,
    input  logic [XLEN-1:0]                  rs2_data_i,
    input  logic [XLEN-1:0]                  jp_addr_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] rd_i,
    input  logic [2:0]                       funct3_i,
    input  logic                             mem_to_reg_i,
    input  logic                             reg_write_i,
    input  logic                             mem_read_i,
    input  logic                             mem_write_i,
    input  logic                             branch_i,
    output logic                             dmem_req_o,
    output logic                             dmem_we_o,
    output logic [XLEN-1:0]                  dmem_addr_o,
    output logic [3:0]                       dmem_be_o,
    output logic [XLEN-1:0]                  dmem_wdata_o,
    input  logic                             dmem_gnt_i,
    input  logic                             dmem_rvalid_i,
    input  logic [XLEN-1:0]                  dmem_rdata_i,
    output logic                             pc_src_o,
    output logic [XLEN-1:0]                  branch_target_o,
    output logic                             stall_o,
    output logic [XLEN-1:0]                  mem_data_o,
    output logic [XLEN-1:0]                  alu_out_o,
    output logic [$clog2(REGFILE_COUNT)-1:0] rd_o,
    output logic                             mem_to_reg_o,
    output logic                             reg_write_o,
    output logic                             err_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state, state_next;

    logic       is_load;
    logic       is_store;
    logic [1:0] addr_lo;
    logic       load_f3_ok;
    logic       store_f3_ok;
    logic       misaligned;
    logic       illegal;
    logic       access_ok;
    logic       req;
    logic       stall;
    logic       done;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;
    logic [XLEN-1:0] load_data;

    assign is_load  = mem_read_i & ~mem_write_i;
    assign is_store = mem_write_i & ~mem_read_i;
    assign addr_lo  = alu_out_i[1:0];

    // Branch resolution is independent of the memory FSM.
    assign pc_src_o        = branch_i & alu_zero_i;
    assign branch_target_o = jp_addr_i;

    // Classify the access: legal funct3 per direction and natural alignment.
    always_comb begin
        load_f3_ok  = 1'b0;
        store_f3_ok = 1'b0;
        misaligned  = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: begin
                load_f3_ok  = 1'b1;
                store_f3_ok = 1'b1;
            end
            3'b100, 3'b101: load_f3_ok = 1'b1;
            default: ;
        endcase
        if (funct3_i[1:0] == 2'b01)
            misaligned = addr_lo[0];
        else if (funct3_i[1:0] == 2'b10)
            misaligned = (addr_lo != 2'b00);
    end

    assign illegal   = (mem_read_i & mem_write_i)
                     | (is_load & ~load_f3_ok)
                     | (is_store & ~store_f3_ok)
                     | ((is_load | is_store) & misaligned);
    assign access_ok = (is_load | is_store) & ~illegal;
    assign done      = (state == WAIT) & dmem_rvalid_i;

    // Handshake state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // Next state, request and stall generation.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (access_ok) begin
                    req        = 1'b1;
                    stall      = 1'b1;
                    state_next = dmem_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                req   = 1'b1;
                stall = 1'b1;
                if (dmem_gnt_i) state_next = WAIT;
            end
            WAIT: begin
                if (dmem_rvalid_i) state_next = IDLE;
                else               stall      = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request and stall drop the moment reset asserts, even with an access presented.
    assign dmem_req_o  = req & rst_ni;
    assign stall_o     = stall & rst_ni;
    assign dmem_we_o   = is_store;
    assign dmem_addr_o = {alu_out_i[XLEN-1:2], 2'b00};

    // Store lane placement and byte enables; loads always read the full word.
    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = rs2_data_i;
        if (is_store) begin
            case (funct3_i[1:0])
                2'b00: begin
                    dmem_be_o    = 4'b0001 << addr_lo;
                    dmem_wdata_o = {4{rs2_data_i[7:0]}};
                end
                2'b01: begin
                    dmem_be_o    = 4'b0011 << addr_lo;
                    dmem_wdata_o = {2{rs2_data_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        case (addr_lo)
            2'b00:   ld_byte = dmem_rdata_i[7:0];
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = addr_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3_i)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = dmem_rdata_i;
        endcase
    end

    // MEM/WB register: bubble while stalled, kill writeback on illegal access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_data_o   <= '0;
            alu_out_o    <= '0;
            rd_o         <= '0;
            mem_to_reg_o <= 1'b0;
            reg_write_o  <= 1'b0;
            err_o        <= 1'b0;
        end else if (stall) begin
            mem_to_reg_o <= 1'b0;
            reg_write_o  <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            alu_out_o    <= alu_out_i;
            rd_o         <= rd_i;
            mem_to_reg_o <= mem_to_reg_i & ~illegal;
            reg_write_o  <= reg_write_i & ~illegal;
            err_o        <= illegal;
            if (done && is_load) mem_data_o <= load_data;
        end
    end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Directed self-checking bench for riscv_mem_stage.
module tb_riscv_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_zero;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [31:0] jp_addr;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] mem_data_q, alu_out_q;
    logic [4:0]  rd_q;
    logic        mem_to_reg_q, reg_write_q, err_q;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    riscv_mem_stage #(
        .XLEN          (32),
        .REGFILE_COUNT (32)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .alu_zero_i      (alu_zero),
        .alu_out_i       (alu_out),
        .rs2_data_i      (rs2_data),
        .jp_addr_i       (jp_addr),
        .rd_i            (rd),
        .funct3_i        (funct3),
        .mem_to_reg_i    (mem_to_reg),
        .reg_write_i     (reg_write),
        .mem_read_i      (mem_read),
        .mem_write_i     (mem_write),
        .branch_i        (branch),
        .dmem_req_o      (dmem_req),
        .dmem_we_o       (dmem_we),
        .dmem_addr_o     (dmem_addr),
        .dmem_be_o       (dmem_be),
        .dmem_wdata_o    (dmem_wdata),
        .dmem_gnt_i      (dmem_gnt),
        .dmem_rvalid_i   (dmem_rvalid),
        .dmem_rdata_i    (dmem_rdata),
        .pc_src_o        (pc_src),
        .branch_target_o (branch_target),
        .stall_o         (stall),
        .mem_data_o      (mem_data_q),
        .alu_out_o       (alu_out_q),
        .rd_o            (rd_q),
        .mem_to_reg_o    (mem_to_reg_q),
        .reg_write_o     (reg_write_q),
        .err_o           (err_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        alu_zero    = 1'b0;
        alu_out     = '0;
        rs2_data    = '0;
        jp_addr     = '0;
        rd          = '0;
        funct3      = '0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
    endtask

    // Load with immediate grant and rvalid one cycle later.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp);
        @(negedge clk);
        clear_inputs();
        alu_out = addr; funct3 = f3; mem_read = 1'b1;
        rd = 5'd7; reg_write = 1'b1; mem_to_reg = 1'b1; dmem_gnt = 1'b1;
        #1 check({tag, "_req"}, 32'(dmem_req), 32'd1);
        check({tag, "_stall"}, 32'(stall), 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1;
        check({tag, "_data"}, mem_data_q, exp);
        check({tag, "_rw"}, 32'(reg_write_q), 32'd1);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_alu", alu_out_q, 32'h0);
        check("rst_rw", 32'(reg_write_q), 32'd0);
        check("rst_err", 32'(err_q), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        rst_n = 1'b1;

        // ALU-only op
        @(negedge clk);
        alu_out = 32'h1234; rd = 5'd5; reg_write = 1'b1;
        #1 check("alu_stall", 32'(stall), 32'd0);
        check("alu_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        check("alu_out", alu_out_q, 32'h1234);
        check("alu_rd", 32'(rd_q), 32'd5);
        check("alu_rw", 32'(reg_write_q), 32'd1);

        // LW at 0x100, gnt immediate, rvalid next cycle
        @(negedge clk);
        clear_inputs();
        alu_out = 32'h100; funct3 = 3'b010; mem_read = 1'b1;
        rd = 5'd6; reg_write = 1'b1; mem_to_reg = 1'b1; dmem_gnt = 1'b1;
        #1 check("lw_addr", dmem_addr, 32'h100);
        check("lw_req", 32'(dmem_req), 32'd1);
        check("lw_we", 32'(dmem_we), 32'd0);
        check("lw_be", 32'(dmem_be), 32'hf);
        check("lw_stall1", 32'(stall), 32'd1);
        @(posedge clk); #1;
        check("lw_bubble", 32'(reg_write_q), 32'd0);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1 check("lw_stall2", 32'(stall), 32'd0);
        check("lw_wait_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        check("lw_data", mem_data_q, 32'hDEADBEEF);
        check("lw_m2r", 32'(mem_to_reg_q), 32'd1);
        check("lw_rw", 32'(reg_write_q), 32'd1);
        check("lw_rd", 32'(rd_q), 32'd6);

        // Byte/halfword loads
        do_load("lb", 32'h103, 3'b000, 32'h80000000, 32'hFFFFFF80);
        do_load("lh", 32'h102, 3'b001, 32'h9ABC1234, 32'hFFFF9ABC);
        do_load("lhu", 32'h100, 3'b101, 32'h0000F00D, 32'h0000F00D);
        do_load("lbu", 32'h103, 3'b100, 32'h80000000, 32'h00000080);

        // SH at 0x102 with gnt delayed 3 cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                clear_inputs();
                alu_out = 32'h102; funct3 = 3'b001; mem_write = 1'b1; rs2_data = 32'h0000ABCD;
            end
            dmem_gnt = (i == 3);
            #1 check("sh_req", 32'(dmem_req), 32'd1);
            check("sh_addr", dmem_addr, 32'h100);
            check("sh_be", 32'(dmem_be), 32'hc);
            check("sh_wdata", dmem_wdata, 32'hABCDABCD);
            check("sh_we", 32'(dmem_we), 32'd1);
            check("sh_stall", 32'(stall), 32'd1);
            @(posedge clk); #1;
            check("sh_rw", 32'(reg_write_q), 32'd0);
        end
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1 check("sh_wait_req", 32'(dmem_req), 32'd0);
        check("sh_wait_stall", 32'(stall), 32'd1);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
        #1 check("sh_done_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("sh_rw_done", 32'(reg_write_q), 32'd0);
        check("sh_memdata_hold", mem_data_q, 32'h00000080);

        // SB lane placement (combinational check only, then complete)
        @(negedge clk);
        clear_inputs();
        alu_out = 32'h101; funct3 = 3'b000; mem_write = 1'b1; rs2_data = 32'h12345678;
        dmem_gnt = 1'b1;
        #1 check("sb_be", 32'(dmem_be), 32'h2);
        check("sb_wdata", dmem_wdata, 32'h78787878);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
        @(negedge clk);
        clear_inputs();

        // Misaligned LW
        alu_out = 32'h101; funct3 = 3'b010; mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
        #1 check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("mis_err", 32'(err_q), 32'd1);
        check("mis_rw", 32'(reg_write_q), 32'd0);
        check("mis_m2r", 32'(mem_to_reg_q), 32'd0);
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
        check("mis_err_pulse", 32'(err_q), 32'd0);

        // Read and write both set
        @(negedge clk);
        alu_out = 32'h200; funct3 = 3'b010; mem_read = 1'b1; mem_write = 1'b1; reg_write = 1'b1;
        #1 check("rw_req", 32'(dmem_req), 32'd0);
        check("rw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("rw_err", 32'(err_q), 32'd1);
        check("rw_rw", 32'(reg_write_q), 32'd0);

        // Reset while in WAIT, then a late rvalid
        @(negedge clk);
        clear_inputs();
        alu_out = 32'h200; funct3 = 3'b010; mem_read = 1'b1; reg_write = 1'b1; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1 check("rst_wait_stall", 32'(stall), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_req", 32'(dmem_req), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_memdata", mem_data_q, 32'h0);
        check("rst_mid_alu", alu_out_q, 32'h0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        #1 check("late_rv_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("late_rv_data", mem_data_q, 32'h0);
        check("late_rv_rw", 32'(reg_write_q), 32'd0);
        @(negedge clk);
        clear_inputs();
        alu_out = 32'h300; funct3 = 3'b010; mem_read = 1'b1;
        #1 check("post_rst_idle_req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Branch outputs
        branch = 1'b1; alu_zero = 1'b1; jp_addr = 32'h400;
        #1 check("br_taken", 32'(pc_src), 32'd1);
        check("br_target", branch_target, 32'h400);
        alu_zero = 1'b0;
        #1 check("br_not_taken", 32'(pc_src), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
